// File: rtl/stoch_pkg.sv
// rtl/stoch_pkg.sv - shared types and constants for the stochastic arithmetic unit
//
// Purpose: arithmetic-mode and FSM-state enums, LFSR geometry constants and
// the gate that combines the two stochastic bitstreams.
// Ports: none (package).

package stoch_pkg;

  localparam int LFSR_W       = 31;
  localparam int TAP_A        = 27;  // x^31 + x^28 + 1
  localparam int TAP_B        = 2;   // x^31 + x^3  + 1
  localparam int PRIME_CYCLES = 2;   // edges needed to fill stage 1 and stage 2

  typedef enum logic [1:0] {
    MODE_BMUL = 2'b00,  // bipolar multiply (XNOR)
    MODE_UMUL = 2'b01,  // unipolar multiply (AND)
    MODE_SADD = 2'b10,  // scaled add (MUX on a random select)
    MODE_PASS = 2'b11   // pass stream A through
  } mode_t;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_PRIME = 2'b01,
    ST_COUNT = 2'b10
  } state_t;

  // One bit of the combined stream for the selected arithmetic mode.
  function automatic logic stoch_gate(input mode_t m, input logic sa,
                                      input logic sb, input logic sel);
    logic y;
    case (m)
      MODE_BMUL: y = ~(sa ^ sb);
      MODE_UMUL: y = sa & sb;
      MODE_SADD: y = sel ? sb : sa;
      default:   y = sa;
    endcase
    return y;
  endfunction

endpackage

// File: rtl/stoch_lfsr.sv
// rtl/stoch_lfsr.sv - free-running Fibonacci LFSR used as a random source
//
// Purpose: shifts left every non-reset cycle; the new bit0 is
// q[WIDTH-1] ^ q[TAP]. A zero seed would lock the register at zero, so it
// is replaced by 1.
// Ports:
//   clk    in   clock, rising edge
//   rst_n  in   synchronous reset, active-high
//   q      out  current LFSR state

module stoch_lfsr #(
  parameter int               WIDTH = 31,
  parameter int               TAP   = 27,
  parameter logic [WIDTH-1:0] SEED  = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic [WIDTH-1:0] q
);

  localparam logic [WIDTH-1:0] SEED_EFF = (SEED == '0) ? WIDTH'(1) : SEED;

  always_ff @(posedge clk) begin
    if (rst_n) begin
      q <= SEED_EFF;
    end else begin
      q <= {q[WIDTH-2:0], q[WIDTH-1] ^ q[TAP]};
    end
  end

endmodule

// File: rtl/stoch_arith_unit.sv
// rtl/stoch_arith_unit.sv - stochastic multiply/add unit with windowed readout
//
// Purpose: turns two binary probabilities into stochastic bitstreams with
// LFSR comparators, combines them with a mode-selected gate and counts the
// ones over a window of N = 2**WIN_LOG2 cycles.
// Ports:
//   clk           in   clock, rising edge
//   rst_n         in   synchronous reset, active-high
//   start         in   conversion request, sampled only when idle
//   mode          in   00 XNOR, 01 AND, 10 MUX, 11 pass A
//   prob_a/prob_b in   operand probabilities, value / 2**PROB_W
//   busy          out  conversion in flight
//   result        out  ones counted in the last window, 0..N
//   result_valid  out  one-cycle pulse when result updates

module stoch_arith_unit #(
  parameter int          PROB_W   = 4,
  parameter int          WIN_LOG2 = 3,
  parameter logic [30:0] SEED_A   = 31'h0000_0001,
  parameter logic [30:0] SEED_B   = 31'h0000_0002
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  input  logic [1:0]          mode,
  input  logic [PROB_W-1:0]   prob_a,
  input  logic [PROB_W-1:0]   prob_b,
  output logic                busy,
  output logic [WIN_LOG2:0]   result,
  output logic                result_valid
);

  import stoch_pkg::*;

  localparam logic [WIN_LOG2-1:0] PRIME_LAST = WIN_LOG2'(PRIME_CYCLES - 1);

  logic [LFSR_W-1:0] lfsr_a;
  logic [LFSR_W-1:0] lfsr_b;

  // Only the top PROB_W bits and bit0 are consumed; the rest of each state
  // is intentionally left untapped.
  logic unused_lfsr;
  assign unused_lfsr = ^{lfsr_a, lfsr_b};

  stoch_lfsr #(.WIDTH(LFSR_W), .TAP(TAP_A), .SEED(SEED_A)) u_lfsr_a (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_a)
  );

  stoch_lfsr #(.WIDTH(LFSR_W), .TAP(TAP_B), .SEED(SEED_B)) u_lfsr_b (
    .clk   (clk),
    .rst_n (rst_n),
    .q     (lfsr_b)
  );

  state_t              state;
  mode_t               mode_q;
  logic [PROB_W-1:0]   prob_a_q;
  logic [PROB_W-1:0]   prob_b_q;
  logic                sn_a;
  logic                sn_b;
  logic                sel;
  logic                comb;
  logic [WIN_LOG2-1:0] phase;   // edge counter within PRIME and COUNT
  logic [WIN_LOG2:0]   count;   // one extra bit so an all-ones window reads N

  always_ff @(posedge clk) begin
    if (rst_n) begin
      state        <= ST_IDLE;
      mode_q       <= MODE_BMUL;
      prob_a_q     <= '0;
      prob_b_q     <= '0;
      sn_a         <= 1'b0;
      sn_b         <= 1'b0;
      sel          <= 1'b0;
      comb         <= 1'b0;
      phase        <= '0;
      count        <= '0;
      result       <= '0;
      result_valid <= 1'b0;
      busy         <= 1'b0;
    end else begin
      // The two pipeline stages run every cycle; PRIME exists only to let
      // freshly captured operands reach comb before counting begins.
      sn_a <= (lfsr_a[LFSR_W-1 -: PROB_W] < prob_a_q);
      sn_b <= (lfsr_b[LFSR_W-1 -: PROB_W] < prob_b_q);
      sel  <= lfsr_a[0] ^ lfsr_b[0];
      comb <= stoch_gate(mode_q, sn_a, sn_b, sel);

      result_valid <= 1'b0;

      case (state)
        ST_IDLE: begin
          if (start) begin
            prob_a_q <= prob_a;
            prob_b_q <= prob_b;
            mode_q   <= mode_t'(mode);
            count    <= '0;
            phase    <= '0;
            busy     <= 1'b1;
            state    <= ST_PRIME;
          end
        end

        ST_PRIME: begin
          if (phase == PRIME_LAST) begin
            phase <= '0;
            state <= ST_COUNT;
          end else begin
            phase <= phase + 1'b1;
          end
        end

        ST_COUNT: begin
          // The final window bit is folded straight into result so the
          // counter never has to hold N and then be read a cycle later.
          if (phase == '1) begin
            result       <= count + (WIN_LOG2+1)'(comb);
            result_valid <= 1'b1;
            busy         <= 1'b0;
            state        <= ST_IDLE;
          end else begin
            count <= count + (WIN_LOG2+1)'(comb);
            phase <= phase + 1'b1;
          end
        end

        default: begin
          busy  <= 1'b0;
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_stoch_arith_unit.sv
// tb/tb_stoch_arith_unit.sv - self-checking bench for stoch_arith_unit

module tb_stoch_arith_unit;

  localparam int          PROB_W   = 4;
  localparam int          WIN_LOG2 = 3;
  localparam int          N        = 1 << WIN_LOG2;
  localparam logic [30:0] SEED_A   = 31'h0000_0001;
  localparam logic [30:0] SEED_B   = 31'h0000_0002;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                start = 1'b0;
  logic [1:0]          mode = 2'b00;
  logic [PROB_W-1:0]   prob_a = '0;
  logic [PROB_W-1:0]   prob_b = '0;
  logic                busy;
  logic [WIN_LOG2:0]   result;
  logic                result_valid;

  int n_checks = 0;
  int n_fail   = 0;
  int shifts   = 0;   // LFSR shifts since the last reset edge

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rst_n) shifts <= 0;
    else       shifts <= shifts + 1;
  end

  stoch_arith_unit #(
    .PROB_W   (PROB_W),
    .WIN_LOG2 (WIN_LOG2),
    .SEED_A   (SEED_A),
    .SEED_B   (SEED_B)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .start        (start),
    .mode         (mode),
    .prob_a       (prob_a),
    .prob_b       (prob_b),
    .busy         (busy),
    .result       (result),
    .result_valid (result_valid)
  );

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference LFSR: shift left, feedback = bit30 xor bit tap, 31-bit mask.
  function automatic longint lfsr_next(input longint v, input int tap);
    longint fb;
    fb = ((v >> 30) ^ (v >> tap)) & 1;
    return ((v << 1) | fb) & 64'h7FFF_FFFF;
  endfunction

  function automatic longint lfsr_after(input longint seed, input int tap, input int n);
    longint v;
    v = seed;
    for (int i = 0; i < n; i++) v = lfsr_next(v, tap);
    return v;
  endfunction

  // Expected ones count: window bit k is derived from the LFSR states present
  // k cycles after the start edge (start edge = s shifts since reset).
  function automatic int model_result(input int m, input int pa, input int pb, input int s);
    longint a, b;
    int cnt, ta, tb, sa, sb, sl, bitv;
    a = lfsr_after(SEED_A, 27, s);
    b = lfsr_after(SEED_B, 2, s);
    cnt = 0;
    for (int k = 0; k < N; k++) begin
      ta = int'((a >> (31 - PROB_W)) & ((1 << PROB_W) - 1));
      tb = int'((b >> (31 - PROB_W)) & ((1 << PROB_W) - 1));
      sa = (ta < pa) ? 1 : 0;
      sb = (tb < pb) ? 1 : 0;
      sl = int'((a ^ b) & 1);
      case (m)
        0:       bitv = (sa == sb) ? 1 : 0;
        1:       bitv = sa & sb;
        2:       bitv = (sl != 0) ? sb : sa;
        default: bitv = sa;
      endcase
      cnt += bitv;
      a = lfsr_next(a, 27);
      b = lfsr_next(b, 2);
    end
    return cnt;
  endfunction

  // Runs one conversion from an idle DUT; called #1 after a clock edge.
  task automatic do_conv(input int m, input int pa, input int pb, input bit scramble,
                         output int res);
    int s, expv, lat;
    bit got;
    start  = 1'b1;
    mode   = 2'(m);
    prob_a = PROB_W'(pa);
    prob_b = PROB_W'(pb);
    @(posedge clk); #1;
    start = 1'b0;
    s = shifts;
    expv = model_result(m, pa, pb, s);
    check_eq("busy_after_start", busy, 1);
    lat = 0;
    got = 0;
    while (lat < 3 * N + 10 && !got) begin
      if (scramble) begin
        mode   = 2'($urandom_range(0, 3));
        prob_a = PROB_W'($urandom);
        prob_b = PROB_W'($urandom);
      end
      @(posedge clk); #1;
      lat++;
      if (result_valid) got = 1;
    end
    check_eq("latency", lat, N + 2);
    check_eq("result_model", result, expv);
    check_eq("result_le_n", (result <= N) ? 1 : 0, 1);
    res = int'(result);
  endtask

  int r;
  int pulses[$];
  int lows;
  int seen;

  initial begin
    // 1: reset state and LFSR progress after 5 free cycles
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check_eq("lfsr_a_5", dut.u_lfsr_a.q, 31'h20);
    check_eq("lfsr_b_5", dut.u_lfsr_b.q, lfsr_after(SEED_B, 2, 5));
    check_eq("reset_busy", busy, 0);
    check_eq("reset_result", result, 0);
    check_eq("reset_valid", result_valid, 0);

    // 2: XNOR of two constant-0 streams is all ones -> N
    do_conv(0, 0, 0, 0, r);
    check_eq("xnor_zero", r, N);

    // 3: zero operands through AND / pass / MUX
    do_conv(1, 15, 0, 0, r);
    check_eq("and_zero", r, 0);
    do_conv(3, 0, 7, 0, r);
    check_eq("pass_zero", r, 0);
    do_conv(2, 0, 0, 0, r);
    check_eq("mux_zero", r, 0);

    // 4: start held high -> one result every N+3 cycles
    start = 1'b1; mode = 2'b00; prob_a = '0; prob_b = '0;
    lows = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (result_valid) begin
        pulses.push_back(i);
        check_eq("b2b_result", result, N);
      end
      if (!busy) lows++;
    end
    start = 1'b0;
    check_eq("b2b_count", pulses.size(), 3);
    check_eq("b2b_p0", pulses[0], N + 2);
    check_eq("b2b_p1", pulses[1], 2 * N + 5);
    check_eq("b2b_p2", pulses[2], 3 * N + 8);
    check_eq("b2b_idle", lows, 3);
    seen = 0;
    for (int i = 0; i < 3 * N && seen == 0; i++) begin
      @(posedge clk); #1;
      if (result_valid) seen = 1;
    end
    check_eq("b2b_drain", seen, 1);

    // 5: reset aborts a conversion; operand changes while busy are ignored
    start = 1'b1; mode = 2'b01; prob_a = 4'd9; prob_b = 4'd5;
    @(posedge clk); #1;
    start = 1'b0;
    seen = 0;
    @(posedge clk); #1;
    prob_a = 4'd3; mode = 2'b10;
    repeat (3) begin
      @(posedge clk); #1;
      if (result_valid) seen++;
    end
    rst_n = 1'b1;
    @(posedge clk); #1;
    rst_n = 1'b0;
    check_eq("abort_busy", busy, 0);
    check_eq("abort_result", result, 0);
    check_eq("abort_valid", result_valid, 0);
    repeat (15) begin
      @(posedge clk); #1;
      if (result_valid) seen++;
    end
    check_eq("abort_no_valid", seen, 0);
    do_conv(1, 9, 5, 0, r);

    // 6: random operands, inputs scrambled while busy
    for (int i = 0; i < 200; i++) begin
      do_conv(int'($urandom_range(0, 3)), int'($urandom_range(0, (1 << PROB_W) - 1)),
              int'($urandom_range(0, (1 << PROB_W) - 1)), 1, r);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
